// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Exports: PC_INC, NOP_INSTR, FETCH_XLEN and the prefetch entry type fetch_entry_t.
package fetch_pkg;

    localparam int          PC_INC     = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam int          FETCH_XLEN = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with synchronous flush and an occupancy count.
// Ports: CLK, RSTn (async, active-low), flush, push/din, pop/dout, empty, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           wr;
    logic           rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign wr    = push && !flush && !full;
    assign rd    = pop && !flush && !empty;
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC/issue over req/gnt+rvalid, prefetch FIFO, decode handshake.
// Ports: CLK, RSTn, br_en/br_addr, imem_req/addr/gnt/rvalid/rdata, if_valid/ready/pc/instr.
// Optional FETCH_MISALIGN_CHK_EN adds if_misalign and misaligned-redirect handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            if_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            misalign;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [XLEN-1:0] br_tgt;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   kill_cnt_q;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     inflight;
    logic            started_q;
    logic            credit_ok;
    logic            halt;
    logic            fire;
    logic            rsp_keep;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    entry_t          din;
    entry_t          head;

`ifdef FETCH_MISALIGN_CHK_EN
    logic halt_q;
    logic mis_pend_q;
    logic br_mis;

    assign br_tgt = br_addr;
    assign br_mis = br_en && (br_addr[1:0] != 2'b00);
    assign halt   = halt_q;

    // A misaligned target halts fetch and queues one marker entry,
    // pushed the cycle after the redirect once the FIFO is flushed.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            halt_q     <= 1'b0;
            mis_pend_q <= 1'b0;
        end else if (br_en) begin
            halt_q     <= br_mis;
            mis_pend_q <= br_mis;
        end else begin
            mis_pend_q <= 1'b0;
        end
    end

    // Marker push never meets a kept response: every response still in
    // flight at the misaligned redirect is on the kill count.
    assign push = rsp_keep || mis_pend_q;

    always_comb begin
        din = '{pc: resp_pc_q, instr: imem_rdata, misalign: 1'b0};
        if (mis_pend_q) begin
            din = '{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
        end
    end

    assign if_misalign = !fifo_empty && head.misalign;
`else
    logic unused_bits;

    assign unused_bits = ^{br_addr[1:0], head.misalign};
    assign br_tgt      = {br_addr[XLEN-1:2], 2'b00};
    assign halt        = 1'b0;
    assign push        = rsp_keep;
    assign din         = '{pc: resp_pc_q, instr: imem_rdata, misalign: 1'b0};
`endif

    // Credit covers both in-flight and buffered fetches, so a kept
    // response always finds a free FIFO slot.
    assign inflight  = {1'b0, outst_q} + {1'b0, fifo_cnt};
    assign credit_ok = inflight < (CW + 1)'(FIFO_DEPTH);

    // started_q keeps the request low in the first cycle after reset.
    assign imem_req  = started_q && !br_en && !halt && credit_ok;
    assign imem_addr = pc_q;
    assign fire      = imem_req && imem_gnt;
    assign rsp_keep  = imem_rvalid && (kill_cnt_q == '0) && !br_en;

    assign if_valid  = !fifo_empty && !br_en;
    assign pop       = if_valid && if_ready;
    assign if_pc     = fifo_empty ? RESET_PC : head.pc;
    assign if_instr  = fifo_empty ? 32'h0 : head.instr;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
        end else begin
            started_q <= 1'b1;
            if (br_en) begin
                pc_q      <= br_tgt;
                resp_pc_q <= br_tgt;
            end else begin
                if (fire) begin
                    pc_q <= pc_q + XLEN'(PC_INC);
                end
                if (rsp_keep) begin
                    resp_pc_q <= resp_pc_q + XLEN'(PC_INC);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            outst_q <= '0;
        end else begin
            unique case ({fire, imem_rvalid})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    // On redirect every fetch still outstanding after this cycle is
    // stale; a response arriving in the redirect cycle is dropped here.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            kill_cnt_q <= '0;
        end else begin
            unique case (1'b1)
                br_en:
                    kill_cnt_q <= outst_q - CW'(imem_rvalid);
                (!br_en && imem_rvalid && kill_cnt_q != '0):
                    kill_cnt_q <= kill_cnt_q - 1'b1;
                default:
                    kill_cnt_q <= kill_cnt_q;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .flush (br_en),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic
// against an in-order memory model and an expected-instruction-stream scoreboard.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    always #5 CLK = ~CLK;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .br_en       (br_en),
        .br_addr     (br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .if_misalign (if_misalign)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pops = 0;
    int          grants = 0;
    int          reqs_seen = 0;
    int          gnt_mode = 1;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rdy_pct = 100;

    logic [31:0] exp_pc = '0;
    logic [31:0] mis_addr = '0;
    bit          halted = 0;
    bit          mis_pend = 0;
    bit          stall_prev = 0;
    logic        last_req = 1'b0;
    logic        last_gnt = 1'b0;
    logic [31:0] last_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic on_pop();
        pops++;
        pop_pc.push_back(if_pc);
        pop_cyc.push_back(cyc);
`ifdef FETCH_MISALIGN_CHK_EN
        if (mis_pend) begin
            chk("mis_pc", if_pc, mis_addr);
            chk("mis_instr", if_instr, 32'h13);
            chk("mis_flag", if_misalign, 1);
            mis_pend = 0;
            halted = 1;
        end else if (halted) begin
            chk("halt_pop", if_valid, 0);
        end else begin
            chk("pop_pc", if_pc, exp_pc);
            chk("pop_instr", if_instr, mem_word(exp_pc));
            chk("pop_mis", if_misalign, 0);
            exp_pc = exp_pc + 32'd4;
        end
`else
        chk("pop_pc", if_pc, exp_pc);
        chk("pop_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
`endif
    endtask

    task automatic on_redirect();
        chk("br_no_valid", if_valid, 0);
        chk("br_no_req", imem_req, 0);
`ifdef FETCH_MISALIGN_CHK_EN
        if (br_addr[1:0] != 2'b00) begin
            mis_pend = 1;
            mis_addr = br_addr;
        end else begin
            mis_pend = 0;
            exp_pc = br_addr;
        end
        halted = 0;
`else
        exp_pc = {br_addr[31:2], 2'b00};
`endif
    endtask

    task automatic step();
        bit fire_req;
        bit fire_pop;
        bit rv;
        rv = RSTn && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata = rv ? mem_word(mq[0].addr) : 32'h0;
        if_ready = ($urandom_range(99) < rdy_pct);
        #1;
        case (gnt_mode)
            0: imem_gnt = 1'b0;
            1: imem_gnt = 1'b1;
            default: imem_gnt = ($urandom_range(99) < 75);
        endcase
        #1;
        fire_req = imem_req && imem_gnt;
        fire_pop = if_valid && if_ready;
        if (RSTn) begin
            if (stall_prev && !br_en) begin
                chk("stall_req", imem_req, 1);
                chk("stall_addr", imem_addr, last_addr);
            end
            if (fire_pop) on_pop();
            if (br_en) on_redirect();
`ifdef FETCH_MISALIGN_CHK_EN
            if ((halted || mis_pend) && !br_en) chk("halt_req", imem_req, 0);
`endif
            if (fire_req) grants++;
            if (imem_req) reqs_seen++;
        end
        stall_prev = RSTn && imem_req && !imem_gnt;
        last_req = imem_req;
        last_gnt = imem_gnt;
        last_addr = imem_addr;
        @(posedge CLK);
        if (rv) void'(mq.pop_front());
        if (fire_req && RSTn) begin
            mq.push_back('{last_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            chk("credit", mq.size() <= 4, 1);
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        br_en = 1'b0;
        mq.delete();
        step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_mis", if_misalign, 0);
`endif
        RSTn = 1'b1;
        cyc = 0;
        exp_pc = '0;
        halted = 0;
        mis_pend = 0;
        stall_prev = 0;
        pop_pc.delete();
        pop_cyc.delete();
        pops = 0;
        grants = 0;
        reqs_seen = 0;
    endtask

    task automatic run_pops(input int more, input int budget);
        int target;
        target = pops + more;
        for (int i = 0; i < budget && pops < target; i++) step();
        chk("pop_timeout", pops >= target, 1);
    endtask

    initial begin
        int n;
        int p0;
        int r0;
        logic [31:0] a0;
        @(negedge CLK);

        // 1: streaming with 1-cycle memory
        gnt_mode = 1; lat_min = 1; lat_max = 1; rdy_pct = 100;
        do_reset();
        run_pops(4, 20);
        for (int i = 0; i < 4; i++) chk("t1_pc", pop_pc[i], 4 * i);
        chk("t1_first_cyc", pop_cyc[0], 3);
        chk("t1_b2b", pop_cyc[3] - pop_cyc[0], 3);

        // 2: decode stalled, credit caps grants at FIFO depth
        rdy_pct = 0;
        do_reset();
        repeat (12) step();
        chk("t2_grants", grants, 4);
        chk("t2_req_off", last_req, 0);
        chk("t2_valid", if_valid, 1);
        rdy_pct = 100;
        run_pops(4, 20);
        for (int i = 0; i < 4; i++) chk("t2_pc", pop_pc[i], 4 * i);
        chk("t2_b2b", pop_cyc[3] - pop_cyc[0], 3);

        // 3: redirect with two slow fetches outstanding
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (3) step();
        chk("t3_grants", grants, 2);
        gnt_mode = 0;
        br_en = 1'b1; br_addr = 32'h100;
        step();
        br_en = 1'b0;
        chk("t3_kill", dut.kill_cnt_q, 2);
        gnt_mode = 1;
        run_pops(1, 30);
        chk("t3_pc", pop_pc[0], 32'h100);

        // 4: redirect coincident with rvalid and if_ready
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (8) step();
        n = mq.size() - (((mq.size() > 0) && (mq[0].due <= cyc)) ? 1 : 0);
        p0 = pops;
        br_en = 1'b1; br_addr = 32'h240;
        step();
        br_en = 1'b0;
        chk("t4_no_pop", pops, p0);
        chk("t4_kill", dut.kill_cnt_q, n);
        pop_pc.delete();
        run_pops(1, 30);
        chk("t4_pc", pop_pc[0], 32'h240);

        // 5: grant withheld for three cycles
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (4) step();
        gnt_mode = 0;
        step();
        a0 = last_addr;
        chk("t5_req0", last_req, 1);
        repeat (2) begin
            step();
            chk("t5_req", last_req, 1);
            chk("t5_addr", last_addr, a0);
        end
        gnt_mode = 1;
        step();
        chk("t5_gnt_addr", last_addr, a0);
        chk("t5_gnt", last_req && last_gnt, 1);
        step();
        chk("t5_next", last_addr, a0 + 32'd4);
        run_pops(4, 20);

        // 6: misaligned redirect target
`ifdef FETCH_MISALIGN_CHK_EN
        br_en = 1'b1; br_addr = 32'h102;
        step();
        br_en = 1'b0;
        p0 = pops;
        r0 = reqs_seen;
        repeat (10) step();
        chk("t6_one_entry", pops - p0, 1);
        chk("t6_no_req", reqs_seen - r0, 0);
        chk("t6_pc", pop_pc[pop_pc.size() - 1], 32'h102);
        br_en = 1'b1; br_addr = 32'h200;
        step();
        br_en = 1'b0;
        run_pops(1, 20);
        chk("t6_resume", pop_pc[pop_pc.size() - 1], 32'h200);
`else
        br_en = 1'b1; br_addr = 32'h102;
        step();
        br_en = 1'b0;
        r0 = reqs_seen;
        step();
        chk("t6_req", last_req, 1);
        chk("t6_addr", last_addr, 32'h100);
        pop_pc.delete();
        run_pops(1, 20);
        chk("t6_pc", pop_pc[0], 32'h100);
`endif

        // randomized traffic
        gnt_mode = 2; lat_min = 1; lat_max = 4; rdy_pct = 70;
        do_reset();
        repeat (3000) begin
            if ($urandom_range(99) < 3) begin
                br_en = 1'b1;
                br_addr = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
                if ($urandom_range(3) != 0) br_addr[1:0] = 2'b00;
`endif
            end
            step();
            br_en = 1'b0;
        end
        chk("rand_live", pops > 300, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
